// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: stall-state and forward-select codes
// and the packed stall/flush control word.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DSTALL = 2'd1,
    ST_ISTALL = 2'd2,
    ST_BRWAIT = 2'd3
  } stallState_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSel_t;

  typedef struct packed {
    logic stallF;
    logic stallD;
    logic stallE;
    logic stallM;
    logic flushD;
    logic flushE;
    logic flushM;
    logic flushW;
  } hazCtl_t;

  function automatic logic anyStall(input hazCtl_t c);
    return c.stallF | c.stallD | c.stallE | c.stallM;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Datapath <-> hazard controller signal bundle; master is the datapath, slave the controller.
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              RegwriteM;
  logic              RegwriteW;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic              MemReadE;
  logic              PCSrcE;
  logic              CacheWaitI;
  logic              CacheWaitD;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              FlushD;
  logic              FlushE;
  logic              FlushM;
  logic              FlushW;
  logic [1:0]        StallReason;
  logic              StallTimeout;
  logic [CNT_W-1:0]  StallCycles;

  modport master (
    output RegwriteM, RegwriteW, RdE, RdM, RdW, Rs1D, Rs2D, Rs1E, Rs2E,
           MemReadE, PCSrcE, CacheWaitI, CacheWaitD,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, StallReason, StallTimeout, StallCycles
  );

  modport slave (
    input  RegwriteM, RegwriteW, RdE, RdM, RdW, Rs1D, Rs2D, Rs1E, Rs2E,
           MemReadE, PCSrcE, CacheWaitI, CacheWaitD,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, FlushM, FlushW, StallReason, StallTimeout, StallCycles
  );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding comparator: selects M, then W, then the register file; x0 never forwards.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic              regWriteM,
  input  logic              regWriteW,
  input  logic [REG_AW-1:0] rdM,
  input  logic [REG_AW-1:0] rdW,
  input  logic [REG_AW-1:0] rsE,
  output fwdSel_t           fwdSel
);

  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && (rdM != '0) && (rdM == rsE))
      fwdSel = FWD_M;
    else if (regWriteW && (rdW != '0) && (rdW == rsE))
      fwdSel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// 5-stage pipeline hazard controller: forwarding, load-use interlock, branch flush, cache-miss
// stalls, registered stall state, sticky stall watchdog and saturating stall-cycle counter.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned MAX_STALL_CYC = 1024,
  parameter int unsigned CNT_W         = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_unit_if.slave hz
);

  localparam int unsigned WD_W = $clog2(MAX_STALL_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL_CYC);

  fwdSel_t          fwdA;
  fwdSel_t          fwdB;
  hazCtl_t          ctl;
  stallState_t      state;
  stallState_t      stateNext;
  logic             loadUse;
  logic             cacheWait;
  logic [WD_W-1:0]  wdCnt;
  logic [WD_W-1:0]  wdNext;
  logic             timeoutQ;
  logic [CNT_W-1:0] stallCnt;

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdA (
    .regWriteM (hz.RegwriteM),
    .regWriteW (hz.RegwriteW),
    .rdM       (hz.RdM),
    .rdW       (hz.RdW),
    .rsE       (hz.Rs1E),
    .fwdSel    (fwdA)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) uFwdB (
    .regWriteM (hz.RegwriteM),
    .regWriteW (hz.RegwriteW),
    .rdM       (hz.RdM),
    .rdW       (hz.RdW),
    .rsE       (hz.Rs2E),
    .fwdSel    (fwdB)
  );

  assign loadUse   = hz.MemReadE && (hz.RdE != '0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign cacheWait = hz.CacheWaitI | hz.CacheWaitD;

  // Priority chain; a D-miss freezes everything up to M so pending branch/load-use
  // hazards simply reappear and resolve once the miss releases.
  always_comb begin
    ctl       = '0;
    stateNext = ST_RUN;
    if (rst) begin
      ctl       = '0;
      stateNext = ST_RUN;
    end else if (hz.CacheWaitD) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.stallE = 1'b1;
      ctl.stallM = 1'b1;
      ctl.flushW = 1'b1;
      stateNext  = ST_DSTALL;
    end else if (hz.CacheWaitI && hz.PCSrcE) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.stallE = 1'b1;
      ctl.flushM = 1'b1;
      stateNext  = ST_BRWAIT;
    end else if (hz.CacheWaitI) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.flushE = 1'b1;
      stateNext  = ST_ISTALL;
    end else if (hz.PCSrcE) begin
      ctl.flushD = 1'b1;
      ctl.flushE = 1'b1;
    end else if (loadUse) begin
      ctl.stallF = 1'b1;
      ctl.stallD = 1'b1;
      ctl.flushE = 1'b1;
    end
  end

  always_comb begin
    wdNext = '0;
    if (cacheWait)
      wdNext = (wdCnt == WD_MAX) ? WD_MAX : wdCnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wdCnt    <= '0;
      timeoutQ <= 1'b0;
      stallCnt <= '0;
    end else begin
      state <= stateNext;
      wdCnt <= wdNext;
      if (wdNext == WD_MAX)
        timeoutQ <= 1'b1;
      if (anyStall(ctl) && (stallCnt != '1))
        stallCnt <= stallCnt + 1'b1;
    end
  end

  assign hz.ForwardAE    = rst ? FWD_RF : fwdA;
  assign hz.ForwardBE    = rst ? FWD_RF : fwdB;
  assign hz.StallF       = ctl.stallF;
  assign hz.StallD       = ctl.stallD;
  assign hz.StallE       = ctl.stallE;
  assign hz.StallM       = ctl.stallM;
  assign hz.FlushD       = ctl.flushD;
  assign hz.FlushE       = ctl.flushE;
  assign hz.FlushM       = ctl.flushM;
  assign hz.FlushW       = ctl.flushW;
  assign hz.StallReason  = state;
  assign hz.StallTimeout = timeoutQ;
  assign hz.StallCycles  = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: combinational vector table plus multi-cycle sequences.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned MAXC   = 8;
  localparam int unsigned CNT_W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  hazard_ctrl_unit #(.REG_AW(REG_AW), .MAX_STALL_CYC(MAXC), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  typedef struct {
    logic       rwM, rwW;
    logic [4:0] rdE, rdM, rdW, rs1D, rs2D, rs1E, rs2E;
    logic       memRd, pcSrc, cwI, cwD;
    logic [1:0] fa, fb;
    logic [7:0] ctl;  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushM,FlushW}
  } vec_t;

  vec_t vecs[13];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctlNow();
    return {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
            hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW};
  endfunction

  function automatic vec_t mk(input logic rwM, input logic rwW,
                              input logic [4:0] rdE, input logic [4:0] rdM, input logic [4:0] rdW,
                              input logic [4:0] rs1D, input logic [4:0] rs2D,
                              input logic [4:0] rs1E, input logic [4:0] rs2E,
                              input logic memRd, input logic pcSrc, input logic cwI, input logic cwD,
                              input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] ctl);
    vec_t v;
    v.rwM = rwM; v.rwW = rwW; v.rdE = rdE; v.rdM = rdM; v.rdW = rdW;
    v.rs1D = rs1D; v.rs2D = rs2D; v.rs1E = rs1E; v.rs2E = rs2E;
    v.memRd = memRd; v.pcSrc = pcSrc; v.cwI = cwI; v.cwD = cwD;
    v.fa = fa; v.fb = fb; v.ctl = ctl;
    return v;
  endfunction

  task automatic clearInputs();
    hz.RegwriteM = 1'b0; hz.RegwriteW = 1'b0;
    hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
    hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
    hz.MemReadE = 1'b0; hz.PCSrcE = 1'b0; hz.CacheWaitI = 1'b0; hz.CacheWaitD = 1'b0;
  endtask

  task automatic applyVec(input vec_t v);
    hz.RegwriteM = v.rwM; hz.RegwriteW = v.rwW;
    hz.RdE = v.rdE; hz.RdM = v.rdM; hz.RdW = v.rdW;
    hz.Rs1D = v.rs1D; hz.Rs2D = v.rs2D; hz.Rs1E = v.rs1E; hz.Rs2E = v.rs2E;
    hz.MemReadE = v.memRd; hz.PCSrcE = v.pcSrc; hz.CacheWaitI = v.cwI; hz.CacheWaitD = v.cwD;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    //           rwM rwW rdE rdM rdW rs1D rs2D rs1E rs2E mem pc cwI cwD  fa     fb     ctl
    vecs[0]  = mk(1, 1,  0,  5,  5,  0,   0,   5,   0,   0,  0, 0,  0,  2'b10, 2'b00, 8'b0000_0000);
    vecs[1]  = mk(1, 1,  0,  0,  5,  0,   0,   5,   0,   0,  0, 0,  0,  2'b01, 2'b00, 8'b0000_0000);
    vecs[2]  = mk(1, 1,  0,  0,  0,  0,   0,   5,   0,   0,  0, 0,  0,  2'b00, 2'b00, 8'b0000_0000);
    vecs[3]  = mk(0, 1,  0,  3,  3,  0,   0,   3,   3,   0,  0, 0,  0,  2'b01, 2'b01, 8'b0000_0000);
    vecs[4]  = mk(1, 1,  0,  0,  0,  0,   0,   0,   0,   0,  0, 0,  0,  2'b00, 2'b00, 8'b0000_0000);
    vecs[5]  = mk(1, 1,  0,  6,  6,  0,   0,   6,   6,   0,  0, 0,  0,  2'b10, 2'b10, 8'b0000_0000);
    vecs[6]  = mk(0, 0,  7,  0,  0,  0,   7,   0,   0,   1,  0, 0,  0,  2'b00, 2'b00, 8'b1100_0100);
    vecs[7]  = mk(0, 0,  0,  0,  0,  0,   0,   0,   0,   1,  0, 0,  0,  2'b00, 2'b00, 8'b0000_0000);
    vecs[8]  = mk(0, 0,  7,  0,  0,  7,   0,   0,   0,   0,  0, 0,  0,  2'b00, 2'b00, 8'b0000_0000);
    vecs[9]  = mk(0, 0,  7,  0,  0,  7,   0,   0,   0,   1,  1, 0,  0,  2'b00, 2'b00, 8'b0000_1100);
    vecs[10] = mk(0, 0,  0,  0,  0,  0,   0,   0,   0,   0,  0, 1,  0,  2'b00, 2'b00, 8'b1100_0100);
    vecs[11] = mk(0, 0,  0,  0,  0,  0,   0,   0,   0,   0,  1, 1,  0,  2'b00, 2'b00, 8'b1110_0010);
    vecs[12] = mk(0, 1,  7,  0,  4,  7,   0,   4,   0,   1,  1, 1,  1,  2'b01, 2'b00, 8'b1111_0001);

    rst = 1'b1;
    clearInputs();
    repeat (2) @(negedge clk);

    // Reset forces outputs low even with a D-miss and a forwarding match present.
    hz.CacheWaitD = 1'b1; hz.RegwriteM = 1'b1; hz.RdM = 5'd9; hz.Rs1E = 5'd9;
    #1;
    chk("rst_ctl", 32'(ctlNow()), 32'h0);
    chk("rst_fwdA", 32'(hz.ForwardAE), 32'h0);
    chk("rst_reason", 32'(hz.StallReason), 32'h0);
    chk("rst_cycles", 32'(hz.StallCycles), 32'h0);
    chk("rst_timeout", 32'(hz.StallTimeout), 32'h0);
    doReset();

    foreach (vecs[i]) begin
      @(negedge clk);
      applyVec(vecs[i]);
      #1;
      chk($sformatf("vec%0d_fa", i), 32'(hz.ForwardAE), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fb", i), 32'(hz.ForwardBE), 32'(vecs[i].fb));
      chk($sformatf("vec%0d_ctl", i), 32'(ctlNow()), 32'(vecs[i].ctl));
    end

    // Load-use for one cycle: stall pulse, state stays RUN.
    doReset();
    @(negedge clk);
    hz.MemReadE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    #1;
    chk("lu_ctl", 32'(ctlNow()), 32'b1100_0100);
    @(negedge clk);
    clearInputs();
    #1;
    chk("lu_after_ctl", 32'(ctlNow()), 32'h0);
    chk("lu_reason", 32'(hz.StallReason), 32'(ST_RUN));

    // D-miss with a pending branch for 10 cycles.
    doReset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hz.CacheWaitD = 1'b1; hz.PCSrcE = 1'b1;
      #1;
      chk($sformatf("dmiss%0d_ctl", i), 32'(ctlNow()), 32'b1111_0001);
      if (i >= 1) chk($sformatf("dmiss%0d_reason", i), 32'(hz.StallReason), 32'(ST_DSTALL));
    end
    @(negedge clk);
    hz.CacheWaitD = 1'b0;
    #1;
    chk("dmiss_rel_ctl", 32'(ctlNow()), 32'b0000_1100);
    chk("dmiss_rel_cycles", 32'(hz.StallCycles), 32'd10);
    chk("dmiss_rel_reason", 32'(hz.StallReason), 32'(ST_DSTALL));
    @(negedge clk);
    hz.PCSrcE = 1'b0;
    #1;
    chk("dmiss_post_reason", 32'(hz.StallReason), 32'(ST_RUN));

    // I-miss with branch for 4 cycles, then the branch resolves.
    doReset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hz.CacheWaitI = 1'b1; hz.PCSrcE = 1'b1;
      #1;
      chk($sformatf("imiss%0d_ctl", i), 32'(ctlNow()), 32'b1110_0010);
      if (i >= 1) chk($sformatf("imiss%0d_reason", i), 32'(hz.StallReason), 32'(ST_BRWAIT));
    end
    @(negedge clk);
    hz.CacheWaitI = 1'b0;
    #1;
    chk("imiss_rel_ctl", 32'(ctlNow()), 32'b0000_1100);
    chk("imiss_rel_reason", 32'(hz.StallReason), 32'(ST_BRWAIT));
    chk("imiss_rel_cycles", 32'(hz.StallCycles), 32'd4);

    // Watchdog with MAX_STALL_CYC=8 and stall counter saturation at 4 bits.
    doReset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hz.CacheWaitD = 1'b1;
      #1;
      chk($sformatf("wd%0d_timeout", i), 32'(hz.StallTimeout), (i >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("wd%0d_cycles", i), 32'(hz.StallCycles), (i >= 15) ? 32'd15 : 32'(i));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hz.CacheWaitD = 1'b0;
      #1;
      chk($sformatf("wd_hold%0d_timeout", i), 32'(hz.StallTimeout), 32'd1);
      chk($sformatf("wd_hold%0d_cycles", i), 32'(hz.StallCycles), 32'd15);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wd_clr_timeout", 32'(hz.StallTimeout), 32'd0);
    rst = 1'b0;

    // Reset asserted in the middle of a D-miss.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hz.CacheWaitD = 1'b1;
    end
    @(negedge clk);
    #1;
    chk("midrst_pre_reason", 32'(hz.StallReason), 32'(ST_DSTALL));
    @(negedge clk);
    rst = 1'b1;
    hz.RegwriteM = 1'b1; hz.RdM = 5'd12; hz.Rs2E = 5'd12;
    #1;
    chk("midrst_ctl", 32'(ctlNow()), 32'h0);
    chk("midrst_fwdB", 32'(hz.ForwardBE), 32'h0);
    @(negedge clk);
    #1;
    chk("midrst_reason", 32'(hz.StallReason), 32'(ST_RUN));
    chk("midrst_cycles", 32'(hz.StallCycles), 32'd0);
    rst = 1'b0;
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Second-generation pipeline hazard controller for the 5-stage RISC-V core with the 2-level cache hierarchy.
- Combines M/W operand forwarding, load-use interlock, taken-branch flush, and I-cache and D-cache miss stalls.
- Adds stall-state tracking, a stall watchdog and a saturating stall-cycle counter.
- Sits beside the datapath. It drives the stall/enable and flush/clear inputs of the F, D, E, M and W pipeline registers.

Parameters:
- REG_AW, 5, register-address width.
- MAX_STALL_CYC, 1024, consecutive cache-stall cycles before the watchdog fires.
- CNT_W, 32, width of the performance stall counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- RegwriteM, RegwriteW  in  1  writeback enables in M and W
- RdE, RdM, RdW  in  REG_AW  destination registers in E, M and W
- Rs1D, Rs2D, Rs1E, Rs2E  in  REG_AW  source registers in D and E
- MemReadE  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- CacheWaitI  in  1  I-cache miss pending (fetch)
- CacheWaitD  in  1  D-cache miss pending (memory)
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = from M, 01 = from W
- StallF, StallD, StallE, StallM  out  1  hold the stage register
- FlushD, FlushE, FlushM, FlushW  out  1  load a bubble into the stage register
- StallReason  out  2  registered state: 0 RUN, 1 DSTALL, 2 ISTALL, 3 BRWAIT
- StallTimeout  out  1  sticky watchdog flag
- StallCycles  out  CNT_W  saturating count of cycles with any stall asserted

Behaviour:
- Reset: while rst=1, all combinational outputs are forced to 0. Next state is RUN. Watchdog counter, StallTimeout and StallCycles clear to 0. Reset asserted mid-stall aborts the stall in that same cycle.
- Forwarding is combinational.
  - ForwardAE=10 if RegwriteM & RdM!=0 & RdM==Rs1E.
  - Else ForwardAE=01 if RegwriteW & RdW!=0 & RdW==Rs1E.
  - Else ForwardAE=00. ForwardBE is the same with Rs2E.
  - M has priority over W.
- LoadUse = MemReadE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- All stall/flush decisions are combinational from the current inputs, so cache waits act in the same cycle. Priority, highest first:
  1. CacheWaitD: StallF=StallD=StallE=StallM=1 and FlushW=1. All other hazards are masked. A pending PCSrcE or LoadUse is held in place and resolves after release.
  2. CacheWaitI & PCSrcE: StallF=StallD=StallE=1 and FlushM=1. The branch waits in E until the I-fetch completes.
  3. CacheWaitI: StallF=StallD=1 and FlushE=1.
  4. PCSrcE: FlushD=FlushE=1. PCSrcE overrides LoadUse, because the dependent instruction is wrong-path.
  5. LoadUse: StallF=StallD=1 and FlushE=1, for exactly one cycle.
  6. Otherwise all stall and flush outputs are 0.
- Stall and flush are never both asserted for the same stage.
- State register (next state follows the active priority case):
  - DSTALL if case 1.
  - BRWAIT if case 2.
  - ISTALL if case 3.
  - RUN otherwise.
  - StallReason is the registered state, so it lags the stall outputs by one cycle.
- Watchdog:
  - Counts consecutive cycles in which CacheWaitI or CacheWaitD is 1, and clears on the first cycle with both at 0.
  - When the count reaches MAX_STALL_CYC, StallTimeout sets and stays set until rst.
  - The counter saturates at MAX_STALL_CYC.
- StallCycles increments on every cycle in which any Stall* output is 1. It saturates at all-ones and never wraps.
- x0 is never a hazard source for forwarding or load-use.

Decomposition:
- Shared package hazard_pkg holds:
  - the StallReason encodings (ST_RUN, ST_DSTALL, ST_ISTALL, ST_BRWAIT);
  - the forward-select encodings (FWD_RF=00, FWD_W=01, FWD_M=10).
- One natural sub-module: hazard_fwd_sel. It is the combinational per-operand forwarding comparator and is instantiated twice, for operands A and B.
- Watchdog and counters stay inline.

Test Plan:
- Forwarding: RegwriteM=1, RdM=5, RegwriteW=1, RdW=5, Rs1E=5 gives ForwardAE=10. Then RdM=0 gives ForwardAE=01. With RdW=0 as well, ForwardAE=00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 for one cycle gives StallF=StallD=1 and FlushE=1 for exactly 1 cycle; StallReason stays 0.
- D-miss with branch: CacheWaitD=1 for 10 cycles while PCSrcE=1.
  - During the miss: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0, StallReason=1 from the 2nd cycle.
  - On release: FlushD=FlushE=1; StallCycles=10.
- I-miss with branch: CacheWaitI=1 and PCSrcE=1 for 4 cycles gives StallE=1, FlushM=1, StallReason=3. The cycle after CacheWaitI drops gives FlushD=FlushE=1.
- Watchdog: MAX_STALL_CYC=8, CacheWaitD held for 20 cycles. StallTimeout rises after 8 cycles, remains 1 after CacheWaitD drops, and clears only when rst=1.
- Reset mid-stall: CacheWaitD=1 and rst=1 together give all Stall*/Flush*=0 that cycle, with StallReason=0 and StallCycles=0 on the next cycle.
